// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select codes and
// the multi-cycle execute unit occupancy states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Address comparison for one source operand: execute-stage forward select
// and the decode-stage load-use hit against the destination in E.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] ra_e,
  input  logic [AW-1:0] ra_d,
  input  logic [AW-1:0] wa3e,
  input  logic [AW-1:0] wa3m,
  input  logic [AW-1:0] wa3w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output fwd_sel_t      fwd,
  output logic          ld_hit
);

  // With a hard-wired zero register, address 0 never carries a real value.
  function automatic logic valid_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && valid_match(ra_e, wa3m)) fwd = FWD_M;
    else if (reg_write_w && valid_match(ra_e, wa3w)) fwd = FWD_W;
  end

  assign ld_hit = valid_match(ra_d, wa3e);

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, multi-cycle execute
// occupancy, memory-wait stall with sticky timeout, and stall-cycle counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NSRC     = 3,
  parameter int ZERO_REG = 1,
  parameter int MUL_LAT  = 4,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [NSRC*AW-1:0]   RAD,
  input  logic [NSRC*AW-1:0]   RAE,
  input  logic [AW-1:0]        WA3E,
  input  logic [AW-1:0]        WA3M,
  input  logic [AW-1:0]        WA3W,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemToRegE,
  input  logic                 MulStartE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  input  logic                 PCSrcD,
  input  logic                 PCSrcE,
  input  logic                 PCSrcM,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 FlushW,
  output logic [NSRC*2-1:0]    ForwardE,
  output logic                 MemTimeout,
  output logic [CNT_W-1:0]     StallCycles
);

  localparam int MCW = $clog2(MUL_LAT);
  localparam int TW  = $clog2(TIMEOUT + 1);

  logic [NSRC-1:0] ld_hit;
  logic            ld_stall, mem_stall, mul_stall, pc_wr_pending;
  logic            stall_f, stall_d, stall_e;
  mul_state_t      state, state_nxt;
  logic [MCW-1:0]  mcnt, mcnt_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_sel_t fwd_sel;
    hazard_fwd_match #(.AW(AW), .ZERO_REG(ZERO_REG)) u_match (
      .ra_e        (RAE[i*AW +: AW]),
      .ra_d        (RAD[i*AW +: AW]),
      .wa3e        (WA3E),
      .wa3m        (WA3M),
      .wa3w        (WA3W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd         (fwd_sel),
      .ld_hit      (ld_hit[i])
    );
    assign ForwardE[i*2 +: 2] = fwd_sel;
  end

  assign mem_stall     = MemReqM & ~MemReadyM;
  assign ld_stall      = MemToRegE & (|ld_hit);
  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= MUL_IDLE;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // A memory wait freezes the multiplier; its own hold covers the E stage.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    if (!mem_stall) begin
      case (state)
        MUL_IDLE: if (MulStartE) begin
          state_nxt = MUL_BUSY;
          mcnt_nxt  = MCW'(MUL_LAT - 2);
        end
        MUL_BUSY: if (mcnt != '0) mcnt_nxt = mcnt - 1'b1;
                  else            state_nxt = MUL_IDLE;
        default:  state_nxt = MUL_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_stall = 1'b0;
    if (!mem_stall) begin
      case (state)
        MUL_IDLE: mul_stall = MulStartE;
        MUL_BUSY: mul_stall = (mcnt != '0);
        default:  mul_stall = 1'b0;
      endcase
    end
  end

  assign stall_e = mem_stall | mul_stall;
  assign stall_d = stall_e | ld_stall;
  assign stall_f = stall_d | pc_wr_pending;

  always_comb begin
    StallM = ~Reset & mem_stall;
    StallE = ~Reset & stall_e;
    StallD = ~Reset & stall_d;
    StallF = ~Reset & stall_f;
    FlushW = ~Reset & mem_stall;
    FlushM = ~Reset & mul_stall;
    FlushE = ~Reset & (ld_stall | BranchTakenE) & ~stall_e;
    FlushD = ~Reset & (pc_wr_pending | PCSrcW | BranchTakenE) & ~stall_d;
  end

  always_comb begin
    tcnt_nxt = '0;
    if (mem_stall) tcnt_nxt = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tcnt        <= '0;
      MemTimeout  <= 1'b0;
      StallCycles <= '0;
    end else begin
      tcnt <= tcnt_nxt;
      if (mem_stall && (tcnt_nxt == TW'(TIMEOUT))) MemTimeout <= 1'b1;
      if (stall_f && (StallCycles != '1)) StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc against an occupancy-based model.
module tb_hazard_unit_mc;

  localparam int AW       = 5;
  localparam int NSRC     = 3;
  localparam int ZERO_REG = 1;
  localparam int MUL_LAT  = 4;
  localparam int TIMEOUT  = 4;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int BW       = 8 + NSRC*2 + 1 + CNT_W;

  logic clk = 1'b0;
  logic Reset;
  logic [NSRC*AW-1:0] RAD, RAE;
  logic [AW-1:0] WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemToRegE, MulStartE, MemReqM, MemReadyM;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [NSRC*2-1:0] ForwardE;
  logic MemTimeout;
  logic [CNT_W-1:0] StallCycles;

  int checks = 0;
  int errors = 0;

  // Model: occ = E-stage cycles already spent by the in-flight multi-cycle op.
  int occ = 0, tcnt_m = 0, cnt_m = 0;
  bit tout_m = 0;
  logic [7:0] exp_ctl;
  logic [NSRC*2-1:0] exp_fwd;

  always #5 clk = ~clk;

  hazard_unit_mc #(.AW(AW), .NSRC(NSRC), .ZERO_REG(ZERO_REG), .MUL_LAT(MUL_LAT),
                   .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset), .RAD(RAD), .RAE(RAE), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE), .MulStartE(MulStartE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW), .ForwardE(ForwardE), .MemTimeout(MemTimeout), .StallCycles(StallCycles)
  );

  function automatic bit vmatch(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && !(ZERO_REG != 0 && a == 0);
  endfunction

  function automatic logic [BW-1:0] obs();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
            ForwardE, MemTimeout, StallCycles};
  endfunction

  function automatic logic [BW-1:0] expv();
    return {exp_ctl, exp_fwd, tout_m, CNT_W'(cnt_m)};
  endfunction

  task automatic predict();
    bit ms, ld, mul, pcw, se, sd, sf;
    logic [AW-1:0] ra;
    if (Reset) begin
      occ = 0; tcnt_m = 0; cnt_m = 0; tout_m = 0;
    end
    ms = MemReqM && !MemReadyM;
    ld = 0;
    exp_fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      ra = RAD[i*AW +: AW];
      if (MemToRegE && vmatch(ra, WA3E)) ld = 1;
      ra = RAE[i*AW +: AW];
      if (RegWriteM && vmatch(ra, WA3M)) exp_fwd[i*2 +: 2] = 2'b10;
      else if (RegWriteW && vmatch(ra, WA3W)) exp_fwd[i*2 +: 2] = 2'b01;
    end
    mul = !ms && ((occ == 0) ? MulStartE : (occ < MUL_LAT - 1));
    pcw = PCSrcD || PCSrcE || PCSrcM;
    se = ms || mul;
    sd = se || ld;
    sf = sd || pcw;
    exp_ctl = {sf, sd, se, ms, (pcw || PCSrcW || BranchTakenE) && !sd,
               (ld || BranchTakenE) && !se, mul, ms};
    if (Reset) exp_ctl = '0;
  endtask

  task automatic model_tick();
    bit ms;
    ms = MemReqM && !MemReadyM;
    if (Reset) begin
      occ = 0; tcnt_m = 0; cnt_m = 0; tout_m = 0;
    end else begin
      if (exp_ctl[7] && cnt_m < CNT_MAX) cnt_m++;
      if (ms) begin
        if (tcnt_m < TIMEOUT) tcnt_m++;
        if (tcnt_m == TIMEOUT) tout_m = 1;
      end else begin
        tcnt_m = 0;
        if (occ == 0) begin
          if (MulStartE) occ = 1;
        end else if (occ == MUL_LAT - 1) occ = 0;
        else occ++;
      end
    end
  endtask

  task automatic advance();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RAD = '0; RAE = '0; WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; MulStartE = 0;
    MemReqM = 0; MemReadyM = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
  endtask

  task automatic pulse_reset();
    Reset = 1;
    #1;
    predict();
    advance();
    Reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    MulStartE = 1; PCSrcD = 1; MemReqM = 1; BranchTakenE = 1;
    for (int c = 0; c < 2; c++) begin
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d: got %b expected %b", c, obs(), expv());
      end
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MemTimeout, StallCycles} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_zero cycle %0d: got %b expected all zero", c, obs());
      end
      advance();
    end
    Reset = 0;
    idle_inputs();
  endtask

  task automatic test_forwarding();
    logic [NSRC*AW-1:0] rae_t [4];
    logic [AW-1:0] wm_t [4], ww_t [4];
    logic rwm_t [4], rww_t [4];
    logic [NSRC*2-1:0] want_t [4];
    rae_t = '{{5'd9, 5'd0, 5'd3}, {5'd9, 5'd0, 5'd3}, {5'd9, 5'd0, 5'd3}, {5'd5, 5'd5, 5'd5}};
    wm_t  = '{5'd3, 5'd0, 5'd3, 5'd5};
    ww_t  = '{5'd3, 5'd0, 5'd9, 5'd5};
    rwm_t = '{1'b1, 1'b1, 1'b0, 1'b1};
    rww_t = '{1'b1, 1'b1, 1'b1, 1'b1};
    want_t = '{6'b000010, 6'b000000, 6'b010000, 6'b101010};
    for (int p = 0; p < 4; p++) begin
      idle_inputs();
      RAE = rae_t[p]; WA3M = wm_t[p]; WA3W = ww_t[p];
      RegWriteM = rwm_t[p]; RegWriteW = rww_t[p];
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL fwd_model pattern %0d: got %b expected %b", p, obs(), expv());
      end
      checks++;
      if (ForwardE !== want_t[p]) begin
        errors++;
        $display("[TB] FAIL fwd_table pattern %0d: got %b expected %b", p, ForwardE, want_t[p]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) begin
        MemToRegE = 1; WA3E = 5'd7; RAD = {5'd7, 5'd1, 5'd2};
      end else if (c == 2) begin
        MemToRegE = 1; WA3E = 5'd0; RAD = '0;
      end
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL load_use cycle %0d: got %b expected %b", c, obs(), expv());
      end
      checks++;
      if ({StallF, StallD, StallE, FlushE} !== ((c == 0) ? 4'b1101 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL load_use_flags cycle %0d: got %b expected %b", c,
                 {StallF, StallD, StallE, FlushE}, (c == 0) ? 4'b1101 : 4'b0000);
      end
      advance();
    end
  endtask

  task automatic test_mul();
    int nse, nfm, cnt0;
    nse = 0; nfm = 0;
    idle_inputs();
    cnt0 = int'(StallCycles);
    for (int c = 0; c < 6; c++) begin
      MulStartE = (c < 4);
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL mul cycle %0d: got %b expected %b", c, obs(), expv());
      end
      nse += int'(StallE);
      nfm += int'(FlushM);
      advance();
    end
    checks++;
    if (nse != MUL_LAT - 1 || nfm != MUL_LAT - 1 || int'(StallCycles) - cnt0 != MUL_LAT - 1) begin
      errors++;
      $display("[TB] FAIL mul_counts: got StallE=%0d FlushM=%0d dCnt=%0d expected %0d each",
               nse, nfm, int'(StallCycles) - cnt0, MUL_LAT - 1);
    end
    idle_inputs();
  endtask

  task automatic test_mul_memwait();
    int nse, nfw;
    nse = 0; nfw = 0;
    idle_inputs();
    for (int c = 0; c < 11; c++) begin
      MulStartE = (c < 9);
      MemReqM = (c >= 1 && c <= 5);
      MemReadyM = 0;
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL mul_memwait cycle %0d: got %b expected %b", c, obs(), expv());
      end
      nse += int'(StallE);
      nfw += int'(FlushW);
      advance();
    end
    checks++;
    if (nse != 8 || nfw != 5) begin
      errors++;
      $display("[TB] FAIL mul_memwait_counts: got StallE=%0d FlushW=%0d expected 8 and 5", nse, nfw);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      MemReqM = (c < TIMEOUT);
      MemReadyM = 0;
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL timeout cycle %0d: got %b expected %b", c, obs(), expv());
      end
      checks++;
      if (MemTimeout !== (c >= TIMEOUT)) begin
        errors++;
        $display("[TB] FAIL timeout_flag cycle %0d: got %b expected %b", c, MemTimeout, c >= TIMEOUT);
      end
      advance();
    end
    idle_inputs();
    pulse_reset();
    checks++;
    if (MemTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got %b expected 0", MemTimeout);
    end
  endtask

  task automatic test_reset_mid_busy();
    idle_inputs();
    MulStartE = 1;
    for (int c = 0; c < 8; c++) begin
      Reset = (c == 2);
      if (c == 6) MulStartE = 0;
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL reset_busy cycle %0d: got %b expected %b", c, obs(), expv());
      end
      if (c == 2) begin
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, StallCycles} !== '0) begin
          errors++;
          $display("[TB] FAIL reset_busy_zero: got %b expected all zero", obs());
        end
      end
      if (c == 3) begin
        checks++;
        if (StallE !== 1'b1) begin
          errors++;
          $display("[TB] FAIL reset_busy_reenter: got StallE=%b expected 1", StallE);
        end
      end
      advance();
    end
    Reset = 0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    pulse_reset();
    PCSrcD = 1;
    for (int c = 0; c < CNT_MAX + 5; c++) begin
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL saturation cycle %0d: got %b expected %b", c, obs(), expv());
      end
      advance();
    end
    checks++;
    if (StallCycles !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("[TB] FAIL saturation_final: got %0d expected %0d", StallCycles, CNT_MAX);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        RAD[i*AW +: AW] = AW'($urandom_range(0, 7));
        RAE[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      WA3E = AW'($urandom_range(0, 7));
      WA3M = AW'($urandom_range(0, 7));
      WA3W = AW'($urandom_range(0, 7));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemToRegE = ($urandom_range(0, 3) == 0);
      MulStartE = ($urandom_range(0, 2) == 0);
      MemReqM = ($urandom_range(0, 3) == 0);
      MemReadyM = 1'($urandom_range(0, 1));
      PCSrcD = ($urandom_range(0, 7) == 0);
      PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0);
      PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      Reset = ($urandom_range(0, 99) == 0);
      #1; predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", c, obs(), expv());
      end
      advance();
    end
    Reset = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul();
    test_mul_memwait();
    test_timeout();
    test_reset_mid_busy();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
